// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM states, default width and counter sizing for the serial adder
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_bit.sv
// serial_add_bit: combinational one-bit full-adder slice
module serial_add_bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one full-adder slice reused LSB first; SERIAL_ADD_SUB_EN adds a subtract port
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = cnt_w(WIDTH);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_r, r_sum;
    logic             r_c, r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_accept, w_last, w_s, w_co, w_c_ld;
    logic [WIDTH-1:0] w_b_ld;

`ifdef SERIAL_ADD_SUB_EN
    assign w_b_ld = sub ? ~b : b;
    assign w_c_ld = sub | carry_in;
`else
    assign w_b_ld = b;
    assign w_c_ld = carry_in;
`endif

    assign w_accept  = start && (r_state == IDLE || r_state == DONE);
    assign w_last    = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
    assign busy      = r_state == RUN;
    assign done      = r_state == DONE;
    assign sum       = r_sum;
    assign carry_out = r_cout;

    serial_add_bit u_bit (
        .a         (r_a[0]),
        .b         (r_b[0]),
        .carry_in  (r_c),
        .sum       (w_s),
        .carry_out (w_co)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state; any illegal encoding falls back to IDLE
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_accept ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = w_accept ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // operand load, per-bit shift/carry, and result capture on the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_r    <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= w_b_ld;
            r_c   <= w_c_ld;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= w_co;
            r_r   <= {w_s, r_r[WIDTH-1:1]};
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= {w_s, r_r[WIDTH-1:1]};
                r_cout <= w_co;
            end
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller that time-shares one full-adder bit slice across a WIDTH-bit operand pair, one bit per clock, LSB first.
- Accepts operands with a start/done handshake.
- Sequences the slice through an IDLE/RUN/DONE state machine and holds the carry in a flop between bits.
- Sits in the combinational-design area as the area-minimal alternative to a ripple-carry adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- carry_in  input  1  initial carry; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.
- sum  output  WIDTH  result; valid from done, held until next accepted start.
- carry_out  output  1  final carry; same validity as sum.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at a clk edge, any state including mid-RUN): state=IDLE, busy=0, done=0, sum=0, carry_out=0, internal shift registers/counter/carry flop cleared. Any in-flight operation is abandoned and produces no done.
- IDLE: when start=1, latch a, b, carry_in into A_sh, B_sh and the carry flop; bit counter cnt=0; go to RUN. Otherwise stay.
- RUN (busy=1): every edge performs the following.
  - s = A_sh[0]^B_sh[0]^c; c_next = majority(A_sh[0], B_sh[0], c).
  - Shift s into result register R from the MSB side; shift A_sh and B_sh right by one.
  - cnt increments.
  - After the edge where cnt==WIDTH-1, go to DONE with sum=R (fully shifted) and carry_out=c_next.
  - start is ignored in RUN; no queuing.
- DONE (done=1, busy=0, exactly one cycle):
  - start=1: accepted exactly as in IDLE, go to RUN. This gives back-to-back operation with no idle bubble.
  - Otherwise go to IDLE.
- Latency: start accepted at edge k, done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from start sampled to done visible. Throughput is one result per WIDTH+1 cycles.
- sum/carry_out update only on entry to DONE and stay stable through IDLE and the following RUN until the next DONE.
- Arithmetic: unsigned modulo 2^WIDTH; carry_out is bit WIDTH of a+b+carry_in.
- cnt width: $clog2(WIDTH). Counter never wraps in normal operation; reset or DONE reinitialises it.
- Illegal state encoding: recover to IDLE on the next edge.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands on an accepted start.
  - sub=1: B_sh loads ~b and the carry flop loads 1, computing a-b; carry_in is ignored.
  - carry_out=1 means no borrow (a>=b, unsigned).
  - sub=0: behaviour is identical to addition.
- Undefined: no sub port, add only; logic is bit-identical to the base design.

Decomposition:
- Package serial_add_pkg:
  - typedef enum state_t {IDLE, RUN, DONE}, 2-bit encoding.
  - localparam default width constant.
  - Helper function for counter width.
- Sub-module: serial_add_bit, the combinational 1-bit full-adder slice (a, b, carry_in -> sum, carry_out). Instantiated once.
- Controller holds the FSM, counter, shift registers and carry flop.

Test Plan:
- Basic add: WIDTH=8, a=8'h35, b=8'h4A, carry_in=0, start 1 cycle -> busy for 8 cycles, done in cycle 9 after start, sum=8'h7F, carry_out=0.
- Carry out: a=8'hFF, b=8'h01, carry_in=0 -> sum=8'h00, carry_out=1. Repeat with carry_in=1, a=8'h80, b=8'h7F -> sum=8'h00, carry_out=1.
- Start while busy: start pulses at cycles 2 and 5 of RUN with different operands -> ignored; exactly one done; result of the first operands only.
- Back-to-back: start held high in DONE with a=8'h01, b=8'h02 -> no IDLE cycle; second done exactly 9 cycles after the first; sum=8'h03.
- Reset mid-op: rst asserted at RUN cycle 4 -> next cycle state IDLE, busy=0, done=0, sum=0, carry_out=0; no done for 20 cycles.
- SERIAL_ADD_SUB_EN defined:
  - sub=1, a=8'h10, b=8'h01 -> sum=8'h0F, carry_out=1.
  - a=8'h01, b=8'h02 -> sum=8'hFF, carry_out=0.
